shift_register_univ: RTL and testbench
======================================

Name: shift_register_univ

Overview:
- Parametrised universal shift register, successor to the fixed 4-bit serial shift register.
- Supports configurable width, bidirectional serial shift, rotate, and parallel load.
- Tracks shifts performed since the last load and flags when a full word has passed through.
- Intended as the operand/result register for the serial adder datapath, so the adder controller can stream WIDTH bits and detect word completion without its own counter.

Parameters:
- WIDTH, 4: register width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1): width of the shift counter; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; when 0, all state holds (reset still acts).
- mode  input  2  operation select: 00 hold, 01 shift, 10 parallel load, 11 rotate.
- dir  input  1  0 = shift/rotate right (toward bit 0); 1 = shift/rotate left (toward MSB).
- d  input  1  serial data in, used in shift mode only.
- pin  input  WIDTH  parallel load data.
- out  output  WIDTH  register contents.
- sout  output  1  serial out; combinational, equals out[0] when dir=0 and out[WIDTH-1] when dir=1.
- cnt  output  CW  number of shift/rotate operations since the last load or reset; saturates at WIDTH.
- done  output  1  registered; high when cnt == WIDTH.

Behaviour:
- Reset: on a rising clk with rst=1, out=0, cnt=0, done=0. Reset has priority over en and mode. Reset mid-stream discards all data and count.
- en=0: out, cnt and done hold, regardless of mode. Only sout can change, and only by following dir.
- en=1 with mode=00 (hold): out, cnt and done unchanged.
- en=1 with mode=01 (shift):
  - dir=0: out <= {d, out[WIDTH-1:1]}.
  - dir=1: out <= {out[WIDTH-2:0], d}.
  - Both directions then apply the counter rule.
- en=1 with mode=11 (rotate):
  - dir=0: out <= {out[0], out[WIDTH-1:1]}.
  - dir=1: out <= {out[WIDTH-2:0], out[WIDTH-1]}.
  - d is ignored. Both directions then apply the counter rule.
- en=1 with mode=10 (load): out <= pin, cnt <= 0, done <= 0. d and dir are ignored.
- Counter rule, for each shift or rotate: if cnt < WIDTH then cnt <= cnt+1, else cnt holds at WIDTH. done <= (next cnt == WIDTH).
  - done therefore rises in the same cycle that the WIDTH-th shift result appears on out.
  - done stays high through further shifts, hold, and en=0 until a load or reset.
- Changing dir or switching between shift and rotate mid-stream is legal. The counter keeps counting across the switch; there is no restart.
- Latency: every state change is visible one cycle after the qualifying edge. sout reflects the new out in that same cycle, with no extra delay.
- No X propagation from d when mode is not shift. All outputs must be defined from the first post-reset cycle.

Test Plan (WIDTH=4 unless noted):
- Reset then hold: rst=1 for one cycle, then en=1, mode=00 for 3 cycles -> out=0000, cnt=0, done=0 throughout.
- Right shift: d = 1,0,1,1 over 4 cycles, mode=01, dir=0 -> out progresses 1000, 0100, 1010, 1101; cnt 1..4; done=1 on the 4th cycle. A 5th shift with d=0 gives out=0110, cnt=4, done=1.
- Load then left shift out: load pin=1011 -> out=1011, cnt=0, done=0. Then 4 shifts with mode=01, dir=1, d=0 -> sout sequence 1,0,1,1 (MSB first), out ends at 0000, done=1.
- Rotate with enable gap: load 1001, rotate right once -> 1100. Then en=0 for 2 cycles -> out still 1100, cnt=1. Re-enable and rotate left twice -> 0011, cnt=3, done=0.
- Reset and load priority: during a shift stream with cnt=2, assert rst with mode=01 -> out=0000, cnt=0 on the next cycle. Separately, load with en=0 -> no change to out.
- Parameter sweep at WIDTH=8: load 0xA5, rotate right 8 times -> out returns to 0xA5, cnt=8, done=1. A subsequent load clears done.

Source files
------------

// File: rtl/shift_register_univ.sv
// shift_register_univ: parametrised universal shift/rotate/load register with saturating shift counter and word-done flag
module shift_register_univ #(
  parameter int WIDTH = 4,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             d,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic [CW-1:0]    cnt,
  output logic             done
);
  logic             shift, load, in_r, in_l;
  logic [WIDTH-1:0] shifted, out_nxt;
  logic [CW-1:0]    cnt_inc, cnt_nxt;
  logic             done_nxt;
  always_comb begin
    shift    = mode[0];
    load     = mode == 2'b10;
    in_r     = mode[1] ? out[0] : d;
    in_l     = mode[1] ? out[WIDTH-1] : d;
    shifted  = dir ? {out[WIDTH-2:0], in_l} : {in_r, out[WIDTH-1:1]};
    cnt_inc  = (cnt == CW'(WIDTH)) ? cnt : cnt + CW'(1);
    out_nxt  = load ? pin : shift ? shifted : out;
    cnt_nxt  = load ? '0 : shift ? cnt_inc : cnt;
    done_nxt = load ? 1'b0 : shift ? (cnt_inc == CW'(WIDTH)) : done;
    sout     = dir ? out[WIDTH-1] : out[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      out  <= out_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_shift_register_univ.sv
// tb_shift_register_univ: directed self-checking bench for shift_register_univ at WIDTH=4 and WIDTH=8
module tb_shift_register_univ;
  logic       clk = 1'b0;
  logic       rst, en, dir, d;
  logic [1:0] mode;
  logic [3:0] pin, out;
  logic [2:0] cnt;
  logic       sout, done;
  logic       rst8, en8, dir8, d8;
  logic [1:0] mode8;
  logic [7:0] pin8, out8;
  logic [3:0] cnt8;
  logic       sout8, done8;
  int         n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  shift_register_univ #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .d(d), .pin(pin),
    .out(out), .sout(sout), .cnt(cnt), .done(done)
  );
  shift_register_univ #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .dir(dir8), .d(d8), .pin(pin8),
    .out(out8), .sout(sout8), .cnt(cnt8), .done(done8)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk4(input string tag, input logic [3:0] eo, input logic [2:0] ec, input logic ed);
    chk({tag, ".out"}, out, eo);
    chk({tag, ".cnt"}, cnt, ec);
    chk({tag, ".done"}, done, ed);
  endtask
  initial begin
    logic [3:0] rs_d    = 4'b1101;
    logic [3:0] rs_out[4] = '{4'h8, 4'h4, 4'hA, 4'hD};
    logic [3:0] ls_sout = 4'b1101;
    rst = 1; en = 0; mode = 0; dir = 0; d = 0; pin = 0;
    rst8 = 1; en8 = 0; mode8 = 0; dir8 = 0; d8 = 0; pin8 = 0;
    step();
    chk4("reset", 4'h0, 3'd0, 1'b0);
    rst = 0; en = 1; mode = 2'b00; d = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk4("hold", 4'h0, 3'd0, 1'b0);
    end
    mode = 2'b01; dir = 0;
    for (int i = 0; i < 4; i++) begin
      d = rs_d[i];
      step();
      chk4("rshift", rs_out[i], 3'(i + 1), i == 3);
    end
    d = 0;
    step();
    chk4("rshift_sat", 4'h6, 3'd4, 1'b1);
    chk("rshift_sout", sout, 1'b0);
    mode = 2'b10; pin = 4'b1011; d = 1; dir = 1;
    step();
    chk4("load", 4'hB, 3'd0, 1'b0);
    mode = 2'b01; dir = 1; d = 0;
    for (int i = 0; i < 4; i++) begin
      chk("lshift_sout", sout, ls_sout[i]);
      step();
    end
    chk4("lshift_end", 4'h0, 3'd4, 1'b1);
    mode = 2'b10; pin = 4'b1001;
    step();
    mode = 2'b11; dir = 0; d = 0;
    step();
    chk4("rot_r", 4'hC, 3'd1, 1'b0);
    en = 0;
    step();
    step();
    chk4("en_gap", 4'hC, 3'd1, 1'b0);
    #1 chk("sout_dir0", sout, 1'b0);
    dir = 1;
    #1 chk("sout_dir1", sout, 1'b1);
    en = 1; d = 1;
    step();
    chk("rot_l1.out", out, 4'h9);
    step();
    chk4("rot_l2", 4'h3, 3'd3, 1'b0);
    mode = 2'b10; pin = 4'h0;
    step();
    mode = 2'b01; dir = 0; d = 1;
    step();
    step();
    chk4("pre_rst", 4'hC, 3'd2, 1'b0);
    rst = 1;
    step();
    chk4("rst_prio", 4'h0, 3'd0, 1'b0);
    rst = 0; en = 0; mode = 2'b10; pin = 4'hF;
    step();
    chk4("load_en0", 4'h0, 3'd0, 1'b0);
    rst8 = 0; en8 = 1; mode8 = 2'b10; pin8 = 8'hA5;
    step();
    chk("w8_load.out", out8, 8'hA5);
    mode8 = 2'b11; dir8 = 0; d8 = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) chk("w8_rot1.out", out8, 8'hD2);
      if (i == 6) chk("w8_rot7.done", done8, 1'b0);
    end
    chk("w8_rot8.out", out8, 8'hA5);
    chk("w8_rot8.cnt", cnt8, 4'd8);
    chk("w8_rot8.done", done8, 1'b1);
    step();
    chk("w8_rot9.cnt", cnt8, 4'd8);
    chk("w8_rot9.done", done8, 1'b1);
    mode8 = 2'b10; pin8 = 8'h3C;
    step();
    chk("w8_reload.out", out8, 8'h3C);
    chk("w8_reload.cnt", cnt8, 4'd0);
    chk("w8_reload.done", done8, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
